spi_bus_arbiter: RTL and testbench
==================================

# spi_bus_arbiter

Round-robin controller that shares one 8-bit SPI master engine among NUM_REQ requesters. Each requester presents a byte with a req/ack handshake. The arbiter grants one requester, drives that requester's active-low chip select with programmable setup and hold guard times, starts the engine and returns a per-requester ack when the byte has been shifted out. It sits between the client blocks and the SPI byte engine, which owns sclk and mosi.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CS_SETUP, 2, clk cycles cs_n is low before eng_start (>=1)
- CS_HOLD, 2, clk cycles cs_n stays low after eng_done (>=1)
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i]
- req_last  in  NUM_REQ  last byte of burst; only used with SPI_ARB_BURST_EN
- ack  out  NUM_REQ  one-cycle pulse: requester's byte completed
- grant_id  out  max(1,$clog2(NUM_REQ))  index of current or last granted requester
- busy  out  1  high in every state except IDLE
- cs_n  out  NUM_REQ  per-device chip select, active low, at most one bit low
- eng_start  out  1  one-cycle pulse starting one byte in the engine
- eng_data  out  8  byte for the engine, stable from eng_start until eng_done
- eng_done  in  1  one-cycle pulse from the engine after the 8th bit

## Operation
- States: IDLE, SETUP, START, WAIT, NEXT (burst build only), HOLD.
- IDLE: if any req bit is set, pick a requester round-robin. The requester after the last granted one has highest priority; after reset, requester 0 is highest. Latch grant_id. Go to SETUP and drive cs_n[g] low.
- SETUP: count CS_SETUP cycles, then go to START.
- START: latch req_data[g] and req_last[g] into eng_data and last_q. Pulse eng_start for one cycle. Go to WAIT.
- WAIT: on eng_done, pulse ack[g] for one cycle. Then go to NEXT if burst is enabled and last_q==0; otherwise go to HOLD.
- NEXT: one cycle for the requester to present the next byte. If req[g]==1, go to START; else go to HOLD.
- HOLD: count CS_HOLD cycles. Then set all cs_n high, advance the priority pointer to g+1 (mod NUM_REQ) and return to IDLE.
- Requester rules:
  - Hold req high with req_data stable until ack.
  - Dropping req before grant withdraws the request.
  - Dropping req after grant is ignored: the byte completes and ack still pulses.
- eng_done outside WAIT is ignored. Requests from other requesters during a transaction wait for IDLE.
- Guard counter width: $clog2(max(CS_SETUP,CS_HOLD)+1). It is cleared on each state entry.
- Reset values:
  - cs_n all 1.
  - ack, eng_start, busy at 0.
  - eng_data 8'h00, grant_id 0.
  - Priority pointer 0. State IDLE.
- Reset mid-transaction: the next edge forces all reset values. cs_n goes high and no ack is issued. The engine shares rst.

## Timing
- Request in IDLE at edge N:
  - cs_n[g] low and busy high from N+1.
  - eng_start high at cycle N+1+CS_SETUP.
- eng_done high in cycle D:
  - ack[g] high in cycle D+1.
  - cs_n[g] high from D+1+CS_HOLD, in non-burst mode.
- cs_n is high for at least one cycle between transactions, because IDLE always lasts at least one cycle.
- Burst: back-to-back bytes are spaced eng_done → ack (+1) → NEXT (+1) → eng_start (+1). cs_n stays low throughout.
- All outputs are registered.

## Configuration
- SPI_ARB_BURST_EN defined:
  - NEXT state exists and req_last is honoured.
  - A granted requester keeps cs_n low across consecutive bytes until a byte with req_last=1 completes, or until req drops during NEXT.
- SPI_ARB_BURST_EN undefined:
  - req_last is ignored and NEXT is not built.
  - Every byte is its own transaction with full setup/hold, and the grant rotates after each byte.

## Structure
- Package spi_arb_pkg: state enum (IDLE, SETUP, START, WAIT, NEXT, HOLD) and default NUM_REQ/CS_SETUP/CS_HOLD localparams.
- Sub-module spi_rr_arbiter:
  - Holds the priority pointer register.
  - Inputs: req vector and advance pulse.
  - Output: one-hot grant plus encoded index.
  - The top block instantiates it once and pulses advance on HOLD exit.

## Test plan
- Reset, then single req[0]=1 with data 8'h5A: cs_n=4'b1110 from N+1, eng_start at N+3, eng_data=8'h5A; engine model returns done at D, then ack[0] at D+1 and cs_n=4'hF at D+3.
- req=4'b1111 held for four transactions: grant order is 0,1,2,3 and each requester gets exactly one ack; then req=4'b1001 gives grants 0, then 3.
- req[2] dropped after grant: the byte still completes and ack[2] pulses; req[1] raised mid-transaction is served next, with cs_n all-high for at least 1 cycle in between.
- rst asserted during WAIT: the next cycle has cs_n=4'hF, busy=0 and no ack; eng_done arriving afterwards is ignored.
- eng_done pulsed while IDLE or SETUP: no ack and no state change.
- With SPI_ARB_BURST_EN, requester 1 sends 3 bytes (last=0,0,1): cs_n[1] stays low across all three, with three acks and three eng_starts each 3 cycles after the preceding done. Without the macro the same stimulus gives three separate cs_n pulses.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI bus arbiter.
// SPI_ARB_BURST_EN selects multi-byte bursts under one chip select.
package spi_arb_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;

`ifdef SPI_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        NEXT  = 3'd4,
        HOLD  = 3'd5
    } arb_state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin requester picker: priority starts one past the last served index.
module spi_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    input  logic [IDW-1:0]     last_id,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (last_id == IDW'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;
        end
    end

    // Scan from ptr upward with wrap; first set request wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDW + 1)'(i);
            if (sum >= (IDW + 1)'(NUM_REQ)) sum = sum - (IDW + 1)'(NUM_REQ);
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI byte engine among NUM_REQ requesters with cs_n setup/hold guards.
// Optional burst mode under SPI_ARB_BURST_EN; dbg = {last_q, state}.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int  NUM_REQ  = DEF_NUM_REQ,
    parameter int  CS_SETUP = DEF_CS_SETUP,
    parameter int  CS_HOLD  = DEF_CS_HOLD,
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   ack,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic [NUM_REQ-1:0]   cs_n,
    output logic                 eng_start,
    output logic [7:0]           eng_data,
    input  logic                 eng_done,
    output logic [3:0]           dbg
);

    localparam int GMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW   = (GMAX + 1 > 1) ? $clog2(GMAX + 1) : 1;

    arb_state_e         state;
    logic [CW-1:0]      cnt;
    logic               last_q;
    logic [NUM_REQ-1:0] arb_oh;
    logic [IDW-1:0]     arb_id;
    logic               advance;
    logic [7:0]         sel_data;
    logic               sel_last;

    assign advance = (state == HOLD) && (cnt == CW'(CS_HOLD - 1));
    assign dbg     = {last_q, state};

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .advance  (advance),
        .last_id  (grant_id),
        .grant    (arb_oh),
        .grant_id (arb_id)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDW'(i)) sel_data = req_data[8*i +: 8];
        end
        sel_last = req_last[grant_id];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_q    <= 1'b0;
            ack       <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            cs_n      <= '1;
            eng_start <= 1'b0;
            eng_data  <= 8'h00;
        end else begin
            ack       <= '0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id <= arb_id;
                        cs_n     <= ~arb_oh;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CW'(CS_SETUP - 1)) begin
                        eng_data  <= sel_data;
                        last_q    <= sel_last;
                        eng_start <= 1'b1;
                        cnt       <= '0;
                        state     <= START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        ack[grant_id] <= 1'b1;
                        cnt           <= '0;
                        state         <= (BURST_EN && !last_q) ? NEXT : HOLD;
                    end
                end
`ifdef SPI_ARB_BURST_EN
                // First NEXT cycle carries the ack; req is sampled in the second,
                // after the requester has had a cycle to present the next byte.
                NEXT: begin
                    if (cnt == '0) begin
                        cnt <= cnt + 1'b1;
                    end else if (req[grant_id]) begin
                        eng_data  <= sel_data;
                        last_q    <= sel_last;
                        eng_start <= 1'b1;
                        cnt       <= '0;
                        state     <= START;
                    end else begin
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (cnt == CW'(CS_HOLD - 1)) begin
                        cs_n  <= '1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cs_n  <= '1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with hand-computed expectations (NUM_REQ=4, setup/hold=2).
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic [3:0]  cs_n;
    logic        eng_start;
    logic [7:0]  eng_data;
    logic        eng_done;
    logic [3:0]  dbg;

    int total = 0;
    int bad   = 0;

    spi_bus_arbiter #(.NUM_REQ(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .cs_n      (cs_n),
        .eng_start (eng_start),
        .eng_data  (eng_data),
        .eng_done  (eng_done),
        .dbg       (dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for eng_start, then run one byte through the engine and retire the requester.
    task automatic serve(input int id, input logic [7:0] data);
        int n;
        logic [3:0] oh;
        n  = 0;
        oh = 4'b0001 << id;
        while (eng_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", {31'd0, eng_start}, 32'd1);
        chk("grant_id", {30'd0, grant_id}, id);
        chk("eng_data", {24'd0, eng_data}, {24'd0, data});
        chk("cs_n_low", {28'd0, cs_n}, {28'd0, ~oh});
        tick();
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("ack", {28'd0, ack}, {28'd0, oh});
        req[id] = 1'b0;
        tick();
        chk("ack_once", {28'd0, ack}, 32'd0);
        chk("cs_n_hold", {28'd0, cs_n}, {28'd0, ~oh});
        tick();
        chk("cs_n_release", {28'd0, cs_n}, 32'hF);
        chk("busy_release", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        req_last = '0;
        eng_done = 1'b0;
        tick();
        tick();
        chk("rst_cs_n", {28'd0, cs_n}, 32'hF);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, eng_start}, 32'd0);
        chk("rst_data", {24'd0, eng_data}, 32'd0);
        chk("rst_gid", {30'd0, grant_id}, 32'd0);
        rst = 1'b0;
        tick();

        // Single request from requester 0: exact setup timing.
        req = 4'b0001;
        req_data[7:0] = 8'h5A;
        tick();
        chk("t1_cs_n", {28'd0, cs_n}, 32'hE);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_no_start_yet", {31'd0, eng_start}, 32'd0);
        tick();
        chk("t1_start", {31'd0, eng_start}, 32'd1);
        serve(0, 8'h5A);

        // All four requesting: rotation 0,1,2,3 from pointer 1 -> 1,2,3,0.
        req_data = 32'h44_33_22_11;
        req = 4'b1111;
        serve(1, 8'h22);
        serve(2, 8'h33);
        serve(3, 8'h44);
        serve(0, 8'h11);
        chk("rr_all_served", {28'd0, req}, 32'd0);

        // req=1001 with pointer at 1: grant 3, then 0.
        req = 4'b1001;
        serve(3, 8'h44);
        serve(0, 8'h11);

        // Requester 2 drops req after grant; requester 1 joins mid-transaction.
        req_data[23:16] = 8'hC3;
        req_data[15:8]  = 8'h77;
        req = 4'b0100;
        tick();
        chk("t3_cs_n", {28'd0, cs_n}, 32'hB);
        req[2] = 1'b0;
        req[1] = 1'b1;
        serve(2, 8'hC3);
        serve(1, 8'h77);

        // Reset during WAIT; late eng_done must be ignored.
        req_data[31:24] = 8'h9E;
        req = 4'b1000;
        tick();
        chk("t4_cs_n", {28'd0, cs_n}, 32'h7);
        tick();
        tick();
        chk("t4_start", {31'd0, eng_start}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        chk("t4_rst_cs_n", {28'd0, cs_n}, 32'hF);
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        chk("t4_rst_ack", {28'd0, ack}, 32'd0);
        chk("t4_rst_gid", {30'd0, grant_id}, 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("t4_late_done_ack", {28'd0, ack}, 32'd0);
        chk("t4_late_done_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t4_late_done_cs_n", {28'd0, cs_n}, 32'hF);

        // eng_done during SETUP is ignored; setup timing unchanged. Pointer reset to 0.
        req_data[15:8] = 8'hA5;
        req = 4'b0010;
        tick();
        chk("t5_cs_n", {28'd0, cs_n}, 32'hD);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("t5_setup_ack", {28'd0, ack}, 32'd0);
        chk("t5_setup_start", {31'd0, eng_start}, 32'd0);
        tick();
        chk("t5_start", {31'd0, eng_start}, 32'd1);
        serve(1, 8'hA5);

        // Requester 1 sends three bytes, last=0,0,1, holding req high throughout.
        req_data[15:8] = 8'hB0;
        req_last[1]    = 1'b0;
        req            = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            int n;
            n = 0;
            while (eng_start !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("bu_start", {31'd0, eng_start}, 32'd1);
            chk("bu_data", {24'd0, eng_data}, {24'd0, 8'hB0 + 8'(b)});
            chk("bu_cs_n", {28'd0, cs_n}, 32'hD);
            tick();
            eng_done = 1'b1;
            tick();
            eng_done = 1'b0;
            chk("bu_ack", {28'd0, ack}, 32'h2);
            req_data[15:8] = 8'hB0 + 8'(b + 1);
            req_last[1]    = (b == 1);
            if (b == 2) req[1] = 1'b0;
            if (b < 2) begin
`ifdef SPI_ARB_BURST_EN
                tick();
                chk("bu_next_cs_n", {28'd0, cs_n}, 32'hD);
                chk("bu_next_start", {31'd0, eng_start}, 32'd0);
                tick();
                chk("bu_restart", {31'd0, eng_start}, 32'd1);
`else
                tick();
                chk("bu_hold_cs_n", {28'd0, cs_n}, 32'hD);
                tick();
                chk("bu_gap_cs_n", {28'd0, cs_n}, 32'hF);
                tick();
                tick();
                tick();
                chk("bu_restart", {31'd0, eng_start}, 32'd1);
`endif
            end else begin
                tick();
                chk("bu_end_hold", {28'd0, cs_n}, 32'hD);
                tick();
                chk("bu_end_cs_n", {28'd0, cs_n}, 32'hF);
                chk("bu_end_busy", {31'd0, busy}, 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
